// File: rtl/pss_pkg.sv
// Shared types, constants and helpers for the PSS peak detector.
package pss_pkg;

    // Detector control states.
    typedef enum logic [1:0] {
        WARMUP  = 2'd0,
        ARMED   = 2'd1,
        HOLDOFF = 2'd2
    } peak_state_t;

    // Largest threshold shift accepted on detection_shift_i.
    localparam int unsigned SHIFT_MAX = 15;

    // Bit width needed to index n items, never less than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pss_peak_window.sv
// Per-channel sliding window: sample history, running sum of the previous
// WINDOW_LEN samples and the combinational hit compare for the current sample.
module pss_peak_window
    import pss_pkg::*;
#(
    parameter int unsigned IN_DW      = 32,
    parameter int unsigned WINDOW_LEN = 8
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             valid_i,
    input  logic [IN_DW-1:0] sample_i,
    input  logic [IN_DW-1:0] noise_limit_i,
    input  logic [3:0]       shift_i,
    output logic             hit_o
);

    localparam int unsigned LOG_W = $clog2(WINDOW_LEN);
    localparam int unsigned SUM_W = IN_DW + LOG_W;
    localparam int unsigned CMP_W = SUM_W + SHIFT_MAX;

    logic [IN_DW-1:0] win_q [WINDOW_LEN];
    logic [SUM_W-1:0] sum_q;
    logic [SUM_W-1:0] sum_d;
    logic [CMP_W-1:0] lhs;
    logic [CMP_W-1:0] rhs;

    // Running sum: add the incoming sample, drop the one leaving the window.
    always_comb begin
        sum_d = sum_q + SUM_W'(sample_i) - SUM_W'(win_q[WINDOW_LEN-1]);
    end

    // Exact compare: x * WINDOW_LEN against S * 2^shift, wide enough for no loss.
    always_comb begin
        lhs   = CMP_W'(sample_i) << LOG_W;
        rhs   = CMP_W'(sum_q) << shift_i;
        hit_o = (sample_i > noise_limit_i) && (lhs > rhs);
    end

    // History shift register and sum advance only on valid samples.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < int'(WINDOW_LEN); i++) begin
                win_q[i] <= '0;
            end
            sum_q <= '0;
        end else if (valid_i) begin
            win_q[0] <= sample_i;
            for (int i = 1; i < int'(WINDOW_LEN); i++) begin
                win_q[i] <= win_q[i-1];
            end
            sum_q <= sum_d;
        end
    end

endmodule

// File: rtl/pss_multi_peak_detector.sv
// Multi-channel PSS peak detector: per-channel sliding-window hit detection,
// largest-magnitude arbitration, sample timestamping and detection hold-off.
// Optional feature: define PSS_PEAK_MAG_OUT_EN to add the peak_mag_o output.
module pss_multi_peak_detector
    import pss_pkg::*;
#(
    parameter int unsigned IN_DW      = 32,
    parameter int unsigned N_CH       = 3,
    parameter int unsigned WINDOW_LEN = 8,
    parameter int unsigned TIME_DW    = 32,
    parameter int unsigned HOLDOFF_DW = 16
) (
    input  logic                         clk_i,
    input  logic                         reset_ni,
    input  logic [N_CH*IN_DW-1:0]        s_axis_in_tdata,
    input  logic                         s_axis_in_tvalid,
    input  logic [IN_DW-1:0]             noise_limit_i,
    input  logic [3:0]                   detection_shift_i,
    input  logic [HOLDOFF_DW-1:0]        holdoff_i,
    input  logic                         enable_i,
    output logic                         peak_detected_o,
    output logic [clog2_min1(N_CH)-1:0]  peak_ch_o,
    output logic [TIME_DW-1:0]           peak_time_o
`ifdef PSS_PEAK_MAG_OUT_EN
    ,
    output logic [IN_DW-1:0]             peak_mag_o
`endif
);

    localparam int unsigned CH_W   = clog2_min1(N_CH);
    localparam int unsigned WARM_W = $clog2(WINDOW_LEN);

    // Per-channel window hits for the sample currently on the input.
    logic [N_CH-1:0] hit;

    // Stage 1 registers.
    logic                  s1_valid_q;
    logic                  s1_en_q;
    logic [N_CH-1:0]       s1_hit_q;
    logic [N_CH*IN_DW-1:0] s1_mag_q;
    logic [TIME_DW-1:0]    s1_time_q;

    // Timestamp of the next valid sample.
    logic [TIME_DW-1:0] ts_q;

    // Control state.
    peak_state_t           state_q, state_d;
    logic [WARM_W-1:0]     warm_q, warm_d;
    logic [HOLDOFF_DW-1:0] hold_q, hold_d;
    logic                  detect;

    // Arbitration result for the stage 1 sample.
    logic             win_found;
    logic [CH_W-1:0]  win_ch;
    logic [IN_DW-1:0] win_mag;

    // Output registers.
    logic               peak_detected_q;
    logic [CH_W-1:0]    peak_ch_q;
    logic [TIME_DW-1:0] peak_time_q;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        pss_peak_window #(
            .IN_DW      (IN_DW),
            .WINDOW_LEN (WINDOW_LEN)
        ) u_win (
            .clk_i         (clk_i),
            .reset_ni      (reset_ni),
            .valid_i       (s_axis_in_tvalid),
            .sample_i      (s_axis_in_tdata[k*IN_DW +: IN_DW]),
            .noise_limit_i (noise_limit_i),
            .shift_i       (detection_shift_i),
            .hit_o         (hit[k])
        );
    end

    // Timestamp advances once per valid sample and wraps naturally.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            ts_q <= '0;
        end else if (s_axis_in_tvalid) begin
            ts_q <= ts_q + TIME_DW'(1);
        end
    end

    // Stage 1: capture hits, magnitudes, timestamp and enable of each sample.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            s1_valid_q <= 1'b0;
            s1_en_q    <= 1'b0;
            s1_hit_q   <= '0;
            s1_mag_q   <= '0;
            s1_time_q  <= '0;
        end else begin
            s1_valid_q <= s_axis_in_tvalid;
            if (s_axis_in_tvalid) begin
                s1_en_q   <= enable_i;
                s1_hit_q  <= hit;
                s1_mag_q  <= s_axis_in_tdata;
                s1_time_q <= ts_q;
            end
        end
    end

    // Arbitration: largest magnitude among hits; strict compare keeps lowest index on ties.
    always_comb begin
        win_found = 1'b0;
        win_ch    = '0;
        win_mag   = '0;
        for (int k = 0; k < int'(N_CH); k++) begin
            if (s1_hit_q[k] && (!win_found || (s1_mag_q[k*IN_DW +: IN_DW] > win_mag))) begin
                win_found = 1'b1;
                win_ch    = CH_W'(k);
                win_mag   = s1_mag_q[k*IN_DW +: IN_DW];
            end
        end
    end

    // Control next state: warm-up count, detection issue and hold-off countdown.
    always_comb begin
        state_d = state_q;
        warm_d  = warm_q;
        hold_d  = hold_q;
        detect  = 1'b0;
        if (s1_valid_q) begin
            unique case (state_q)
                WARMUP: begin
                    warm_d = warm_q + WARM_W'(1);
                    if (warm_q == WARM_W'(WINDOW_LEN - 1)) begin
                        state_d = ARMED;
                    end
                end
                ARMED: begin
                    if (s1_en_q && win_found) begin
                        detect = 1'b1;
                        if (holdoff_i != '0) begin
                            state_d = HOLDOFF;
                            hold_d  = holdoff_i;
                        end
                    end
                end
                HOLDOFF: begin
                    // The sample that brings the count to zero is still suppressed.
                    hold_d = hold_q - HOLDOFF_DW'(1);
                    if (hold_q == HOLDOFF_DW'(1)) begin
                        state_d = ARMED;
                    end
                end
                default: begin
                    state_d = WARMUP;
                end
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= WARMUP;
            warm_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            warm_q  <= warm_d;
            hold_q  <= hold_d;
        end
    end

    // Stage 2: detection pulse; channel and time hold until the next detection.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            peak_detected_q <= 1'b0;
            peak_ch_q       <= '0;
            peak_time_q     <= '0;
        end else begin
            peak_detected_q <= detect;
            if (detect) begin
                peak_ch_q   <= win_ch;
                peak_time_q <= s1_time_q;
            end
        end
    end

`ifdef PSS_PEAK_MAG_OUT_EN
    logic [IN_DW-1:0] peak_mag_q;

    // Winning magnitude, updated together with the channel.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            peak_mag_q <= '0;
        end else if (detect) begin
            peak_mag_q <= win_mag;
        end
    end

    assign peak_mag_o = peak_mag_q;
`endif

    assign peak_detected_o = peak_detected_q;
    assign peak_ch_o       = peak_ch_q;
    assign peak_time_o     = peak_time_q;

endmodule

// File: tb/tb_pss_multi_peak_detector.sv
// Scoreboard bench for pss_multi_peak_detector: a rule-level reference model
// predicts each detection and its output cycle; a monitor checks every cycle.
module tb_pss_multi_peak_detector;

    localparam int IN_DW      = 32;
    localparam int N_CH       = 3;
    localparam int WINDOW_LEN = 8;
    localparam int TIME_DW    = 32;
    localparam int HOLDOFF_DW = 16;

    logic                  clk;
    logic                  rst_n;
    logic [N_CH*IN_DW-1:0] s_axis_in_tdata;
    logic                  s_axis_in_tvalid;
    logic [IN_DW-1:0]      noise_limit_i;
    logic [3:0]            detection_shift_i;
    logic [HOLDOFF_DW-1:0] holdoff_i;
    logic                  enable_i;
    logic                  peak_detected_o;
    logic [1:0]            peak_ch_o;
    logic [TIME_DW-1:0]    peak_time_o;
`ifdef PSS_PEAK_MAG_OUT_EN
    logic [IN_DW-1:0]      peak_mag_o;
`endif

    pss_multi_peak_detector #(
        .IN_DW      (IN_DW),
        .N_CH       (N_CH),
        .WINDOW_LEN (WINDOW_LEN),
        .TIME_DW    (TIME_DW),
        .HOLDOFF_DW (HOLDOFF_DW)
    ) dut (
        .clk_i             (clk),
        .reset_ni          (rst_n),
        .s_axis_in_tdata   (s_axis_in_tdata),
        .s_axis_in_tvalid  (s_axis_in_tvalid),
        .noise_limit_i     (noise_limit_i),
        .detection_shift_i (detection_shift_i),
        .holdoff_i         (holdoff_i),
        .enable_i          (enable_i),
        .peak_detected_o   (peak_detected_o),
        .peak_ch_o         (peak_ch_o),
        .peak_time_o       (peak_time_o)
`ifdef PSS_PEAK_MAG_OUT_EN
        ,
        .peak_mag_o        (peak_mag_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int det_count = 0;

    typedef struct {
        int     cyc;
        int     ch;
        longint t;
        longint mag;
    } exp_t;

    exp_t sb[$];

    // Reference model state.
    longint hist [N_CH][$];
    int     nsamp;
    int     hold_cnt;
    longint ts;

    // Stimulus values for the next sample.
    longint cur [N_CH];
    longint b_noise;
    int     b_shift;
    bit     b_en;

    task automatic chk(input string nm, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N_CH; k++) hist[k].delete();
        nsamp    = 0;
        hold_cnt = 0;
        ts       = 0;
        sb.delete();
    endtask

    // One valid sample, applied by the rules: window mean threshold, noise
    // floor, warm-up, largest-wins arbitration and hold-off counting.
    task automatic model_sample(input int at_cyc);
        longint s;
        longint best;
        int     bi;
        bit     found;
        bit     h;
        exp_t   e;
        found = 0;
        bi    = 0;
        best  = 0;
        for (int k = 0; k < N_CH; k++) begin
            s = 0;
            for (int i = 0; i < hist[k].size(); i++) s += hist[k][i];
            h = (cur[k] > b_noise) && ((cur[k] * WINDOW_LEN) > (s * (longint'(1) << b_shift)));
            if (h && (!found || cur[k] > best)) begin
                found = 1;
                best  = cur[k];
                bi    = k;
            end
        end
        if (hold_cnt > 0) begin
            hold_cnt--;
        end else if (nsamp >= WINDOW_LEN && b_en && found) begin
            e.cyc = at_cyc + 2;
            e.ch  = bi;
            e.t   = ts;
            e.mag = best;
            sb.push_back(e);
            hold_cnt = int'(holdoff_i);
        end
        for (int k = 0; k < N_CH; k++) begin
            hist[k].push_back(cur[k]);
            if (hist[k].size() > WINDOW_LEN) void'(hist[k].pop_front());
        end
        nsamp++;
        ts = (ts + 1) & 64'hFFFF_FFFF;
    endtask

    // Present one cycle of input; config rides along with the data.
    task automatic send(input bit v);
        @(posedge clk);
        #1;
        s_axis_in_tvalid  = v;
        noise_limit_i     = IN_DW'(b_noise);
        detection_shift_i = 4'(b_shift);
        enable_i          = b_en;
        for (int k = 0; k < N_CH; k++) begin
            s_axis_in_tdata[k*IN_DW +: IN_DW] = v ? IN_DW'(cur[k]) : IN_DW'($urandom);
        end
        if (v) model_sample(cyc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(1'b0);
    endtask

    task automatic fill(input longint v0, input longint v1, input longint v2, input int n);
        cur[0] = v0;
        cur[1] = v1;
        cur[2] = v2;
        for (int i = 0; i < n; i++) send(1'b1);
    endtask

    // holdoff_i is used one cycle after the sample, so change it only when idle.
    task automatic set_holdoff(input int v);
        idle(3);
        holdoff_i = HOLDOFF_DW'(v);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst_n            = 1'b0;
        s_axis_in_tvalid = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rst_detect", peak_detected_o, 0);
        chk("rst_ch", peak_ch_o, 0);
        chk("rst_time", peak_time_o, 0);
`ifdef PSS_PEAK_MAG_OUT_EN
        chk("rst_mag", peak_mag_o, 0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: compare detection pulse, channel and time against the scoreboard.
    longint last_ch;
    longint last_t;
    longint last_mag;
    always @(negedge clk) begin
        automatic exp_t e;
        automatic bit   exp_now;
        if (!rst_n) begin
            last_ch  = 0;
            last_t   = 0;
            last_mag = 0;
        end else begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                chk("missed_detect_cycle", cyc, e.cyc);
            end
            exp_now = (sb.size() > 0) && (sb[0].cyc == cyc);
            chk("detect", peak_detected_o, exp_now);
            if (peak_detected_o) det_count++;
            if (exp_now) begin
                e        = sb.pop_front();
                last_ch  = e.ch;
                last_t   = e.t;
                last_mag = e.mag;
            end
            chk("peak_ch", peak_ch_o, last_ch);
            chk("peak_time", peak_time_o, last_t);
`ifdef PSS_PEAK_MAG_OUT_EN
            chk("peak_mag", peak_mag_o, last_mag);
`endif
        end
    end

    int d0;
    int r;

    initial begin
        rst_n             = 1'b0;
        s_axis_in_tvalid  = 1'b0;
        s_axis_in_tdata   = '0;
        noise_limit_i     = '0;
        detection_shift_i = '0;
        holdoff_i         = '0;
        enable_i          = 1'b0;
        b_noise           = 0;
        b_shift           = 2;
        b_en              = 1'b1;
        for (int k = 0; k < N_CH; k++) cur[k] = 0;
        model_reset();
        apply_reset();

        // Warm-up: the 8th sample cannot detect, the 9th does at time 8.
        d0 = det_count;
        fill(1000, 0, 0, 7);
        fill(100000, 0, 0, 1);
        idle(3);
        chk("warmup_no_detect", det_count - d0, 0);
        fill(100000, 0, 0, 1);
        idle(3);
        chk("warmup_detect", det_count - d0, 1);
        chk("warmup_ch", peak_ch_o, 0);
        chk("warmup_time", peak_time_o, 8);

        // Threshold equality is not a hit; one above is.
        b_shift = 3;
        d0 = det_count;
        fill(100, 0, 0, 8);
        fill(800, 0, 0, 1);
        idle(3);
        chk("thresh_equal", det_count - d0, 0);
        fill(100, 0, 0, 8);
        fill(801, 0, 0, 1);
        idle(3);
        chk("thresh_above", det_count - d0, 1);

        // Noise floor.
        b_shift = 0;
        b_noise = 5000;
        d0 = det_count;
        fill(0, 0, 0, 8);
        fill(4000, 0, 0, 1);
        idle(3);
        chk("noise_below", det_count - d0, 0);
        fill(0, 0, 0, 8);
        fill(6000, 0, 0, 1);
        idle(3);
        chk("noise_above", det_count - d0, 1);

        // Arbitration: tie goes to the lower index, strictly larger wins.
        b_noise = 0;
        fill(0, 0, 0, 8);
        fill(500, 900, 900, 1);
        idle(3);
        chk("arb_tie", peak_ch_o, 1);
        fill(500, 900, 901, 1);
        idle(3);
        chk("arb_larger", peak_ch_o, 2);

        // Hold-off of 3 over five consecutive peaks, then hold-off 0.
        set_holdoff(3);
        fill(0, 0, 0, 8);
        d0 = det_count;
        for (int i = 0; i < 5; i++) fill(longint'(1000) << i, 0, 0, 1);
        idle(3);
        chk("holdoff3_count", det_count - d0, 2);
        set_holdoff(0);
        fill(0, 0, 0, 8);
        d0 = det_count;
        for (int i = 0; i < 5; i++) fill(longint'(1000) << i, 0, 0, 1);
        idle(3);
        chk("holdoff0_count", det_count - d0, 5);

        // Reset while in hold-off, then warm-up restarts with timestamp 0.
        set_holdoff(50);
        fill(0, 0, 0, 8);
        fill(1000, 0, 0, 1);
        fill(0, 0, 0, 3);
        idle(3);
        apply_reset();
        b_shift = 2;
        set_holdoff(0);
        d0 = det_count;
        fill(1000, 0, 0, 7);
        fill(100000, 0, 0, 2);
        idle(3);
        chk("post_reset_detect", det_count - d0, 1);
        chk("post_reset_time", peak_time_o, 8);

        // Randomized phases against the reference model.
        for (int p = 0; p < 6; p++) begin
            set_holdoff($urandom_range(0, 5));
            for (int i = 0; i < 300; i++) begin
                b_noise = $urandom_range(0, 2000);
                b_shift = $urandom_range(0, 4);
                b_en    = ($urandom_range(0, 9) != 0);
                for (int k = 0; k < N_CH; k++) begin
                    r = $urandom_range(0, 99);
                    if (r < 6) cur[k] = longint'($urandom);
                    else if (r < 15) cur[k] = $urandom_range(2000, 20000);
                    else cur[k] = $urandom_range(0, 1500);
                end
                send($urandom_range(0, 4) != 0);
            end
        end
        idle(5);
        chk("scoreboard_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
